// File: rtl/hazard_stall_control.sv
// Pipeline hold/flush/bubble sequencing for the 5-stage RV32I core.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_instr_opcode_ip,
  input  logic [4:0]       ID_rs1_ip,
  input  logic [4:0]       ID_rs2_ip,
  input  logic             ID_EX_mem_read_ip,
  input  logic [4:0]       ID_EX_dest_ip,
  input  logic             ex_redirect_ip,
  input  logic             dmem_req_ip,
  input  logic             dmem_ready_ip,
  output logic             pc_stall_op,
  output logic             if_id_stall_op,
  output logic             if_id_flush_op,
  output logic             id_ex_stall_op,
  output logic             id_ex_bubble_op,
  output logic             ex_mem_stall_op,
  output logic             mem_wb_bubble_op,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] load_use_cnt_op,
  output logic [CNT_W-1:0] redirect_cnt_op,
  output logic [CNT_W-1:0] mem_stall_cnt_op,
`endif
  output logic             mem_timeout_op
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitOne = WaitW'(1);

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : gen_param_check
    $error("hazard_stall_control: MEM_TIMEOUT and CNT_W must be at least 1");
  end

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic rs1_used, rs2_used;
  logic load_use, mem_busy, mem_stall;
  logic redirect_win, load_use_win;

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (id_instr_opcode_ip)
      OpcBranch, OpcStore, OpcOp: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OpcLoad, OpcJalr, OpcOpImm: rs1_used = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    load_use = ID_EX_mem_read_ip && (ID_EX_dest_ip != 5'd0) &&
               ((rs1_used && (ID_rs1_ip == ID_EX_dest_ip)) ||
                (rs2_used && (ID_rs2_ip == ID_EX_dest_ip)));
    mem_busy     = dmem_req_ip && !dmem_ready_ip;
    // A held EX redirect stays pending until MEM_WAIT releases the pipeline.
    mem_stall    = (state_q == StMemWait) || mem_busy;
    redirect_win = ex_redirect_ip && !mem_stall;
    load_use_win = load_use && !mem_stall && !ex_redirect_ip;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          state_d    = StMemWait;
          wait_cnt_d = WaitOne;
        end
      end
      StMemWait: begin
        // A dropped request is a protocol violation; simply fall back to RUN.
        if (dmem_ready_ip || !dmem_req_ip) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitMax) begin
          wait_cnt_d = wait_cnt_q + WaitOne;
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
    timeout_d = timeout_q || (wait_cnt_d == WaitMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    pc_stall_op      = 1'b0;
    if_id_stall_op   = 1'b0;
    if_id_flush_op   = 1'b0;
    id_ex_stall_op   = 1'b0;
    id_ex_bubble_op  = 1'b0;
    ex_mem_stall_op  = 1'b0;
    mem_wb_bubble_op = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        pc_stall_op      = 1'b1;
        if_id_stall_op   = 1'b1;
        id_ex_stall_op   = 1'b1;
        ex_mem_stall_op  = 1'b1;
        mem_wb_bubble_op = 1'b1;
      end else if (redirect_win) begin
        if_id_flush_op  = 1'b1;
        id_ex_bubble_op = 1'b1;
      end else if (load_use_win) begin
        pc_stall_op     = 1'b1;
        if_id_stall_op  = 1'b1;
        id_ex_bubble_op = 1'b1;
      end
    end
    mem_timeout_op = timeout_q && !reset;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, rd_cnt_q, ms_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt_q <= '0;
      rd_cnt_q <= '0;
      ms_cnt_q <= '0;
    end else begin
      if (load_use_win) lu_cnt_q <= lu_cnt_q + 1'b1;
      if (redirect_win) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (mem_stall)    ms_cnt_q <= ms_cnt_q + 1'b1;
    end
  end

  always_comb begin
    load_use_cnt_op  = reset ? '0 : lu_cnt_q;
    redirect_cnt_op  = reset ? '0 : rd_cnt_q;
    mem_stall_cnt_op = reset ? '0 : ms_cnt_q;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_control.sv
// Self-checking bench for hazard_stall_control: directed steps followed by random traffic,
// checked against a cycle-level behavioural model of the stall rules.
module tb_hazard_stall_control;

  localparam int unsigned TOUT = 4;

  localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, STORE = 7'b0100011;
  localparam logic [6:0] OP = 7'b0110011, BRANCH = 7'b1100011, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall, mem_wb_bubble}
  localparam logic [6:0] V_NONE = 7'b0000000;
  localparam logic [6:0] V_MEM  = 7'b1101011;
  localparam logic [6:0] V_RED  = 7'b0010100;
  localparam logic [6:0] V_LU   = 7'b1100100;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opc;
  logic [4:0] rs1, rs2, dest;
  logic       mem_read, redirect, req, ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
  logic       ex_mem_stall, mem_wb_bubble, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt, rd_cnt, ms_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state, in plain terms: are we waiting, for how many cycles, timed out yet.
  bit          m_waiting = 0;
  int          m_wait_cycles = 0;
  bit          m_timed_out = 0;
  logic [31:0] m_lu = 0, m_rd = 0, m_ms = 0;

  logic [6:0] opc_tab [0:9] = '{LOAD, OPIMM, STORE, OP, BRANCH, JALR, LUI, AUIPC, JAL, 7'b0001111};

  always #5 clk = ~clk;

  hazard_stall_control #(.MEM_TIMEOUT(TOUT), .CNT_W(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .id_instr_opcode_ip (opc),
    .ID_rs1_ip          (rs1),
    .ID_rs2_ip          (rs2),
    .ID_EX_mem_read_ip  (mem_read),
    .ID_EX_dest_ip      (dest),
    .ex_redirect_ip     (redirect),
    .dmem_req_ip        (req),
    .dmem_ready_ip      (ready),
    .pc_stall_op        (pc_stall),
    .if_id_stall_op     (if_id_stall),
    .if_id_flush_op     (if_id_flush),
    .id_ex_stall_op     (id_ex_stall),
    .id_ex_bubble_op    (id_ex_bubble),
    .ex_mem_stall_op    (ex_mem_stall),
    .mem_wb_bubble_op   (mem_wb_bubble),
`ifdef HAZARD_PERF_CNT_EN
    .load_use_cnt_op    (lu_cnt),
    .redirect_cnt_op    (rd_cnt),
    .mem_stall_cnt_op   (ms_cnt),
`endif
    .mem_timeout_op     (mem_timeout)
  );

  // One cycle: drive at negedge, compare just after, advance the model at posedge.
  task automatic step(input string tag, input logic rst, input logic [6:0] o,
                      input logic [4:0] r1, input logic [4:0] r2, input logic mr,
                      input logic [4:0] d, input logic red, input logic rq, input logic rdy,
                      input bit use_want = 0, input logic [6:0] want = 7'd0);
    bit         reads1, reads2, hazard, mstall;
    logic [6:0] exp_v, obs_v;
    logic       exp_to;
    @(negedge clk);
    reset = rst; opc = o; rs1 = r1; rs2 = r2; mem_read = mr; dest = d;
    redirect = red; req = rq; ready = rdy;
    #1;
    reads1 = (o inside {BRANCH, STORE, OP, LOAD, JALR, OPIMM});
    reads2 = (o inside {BRANCH, STORE, OP});
    hazard = mr && (d != 0) && ((reads1 && r1 == d) || (reads2 && r2 == d));
    mstall = m_waiting || (rq && !rdy);
    if (rst)         exp_v = V_NONE;
    else if (mstall) exp_v = V_MEM;
    else if (red)    exp_v = V_RED;
    else if (hazard) exp_v = V_LU;
    else             exp_v = V_NONE;
    exp_to = rst ? 1'b0 : m_timed_out;
    obs_v = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_stall,
             mem_wb_bubble};
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs_v, exp_v);
    end
    checks++;
    assert (mem_timeout === exp_to) else begin
      failures++;
      $error("FAIL %s timeout observed=%b expected=%b", tag, mem_timeout, exp_to);
    end
    if (use_want) begin
      checks++;
      assert (obs_v === want) else begin
        failures++;
        $error("FAIL %s directed observed=%b expected=%b", tag, obs_v, want);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    assert ({lu_cnt, rd_cnt, ms_cnt} === (rst ? 96'd0 : {m_lu, m_rd, m_ms})) else begin
      failures++;
      $error("FAIL %s counters observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
             lu_cnt, rd_cnt, ms_cnt, m_lu, m_rd, m_ms);
    end
`endif
    @(posedge clk);
    if (rst) begin
      m_waiting = 0; m_wait_cycles = 0; m_timed_out = 0;
      m_lu = 0; m_rd = 0; m_ms = 0;
    end else begin
      if (exp_v == V_LU)  m_lu++;
      if (exp_v == V_RED) m_rd++;
      if (exp_v == V_MEM) m_ms++;
      if (m_waiting) begin
        if (rdy || !rq) begin
          m_waiting = 0;
          m_wait_cycles = 0;
        end else begin
          m_wait_cycles++;
        end
      end else if (rq && !rdy) begin
        m_waiting = 1;
        m_wait_cycles = 1;
      end
      if (m_wait_cycles >= TOUT) m_timed_out = 1;
    end
  endtask

  initial begin
    reset = 1; opc = 0; rs1 = 0; rs2 = 0; mem_read = 0; dest = 0;
    redirect = 0; req = 0; ready = 0;

    step("reset0", 1, OP, 5'd5, 5'd7, 1, 5'd5, 0, 1, 0, 1, V_NONE);
    step("reset1", 1, OP, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, V_NONE);
    step("idle",   0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, V_NONE);

    // lw x5 ; add x6,x5,x7
    step("lu_rs1",   0, OP,  5'd5, 5'd7, 1, 5'd5, 0, 0, 0, 1, V_LU);
    step("lu_after", 0, OP,  5'd6, 5'd7, 0, 5'd0, 0, 0, 0, 1, V_NONE);
    step("lu_rs2",   0, STORE, 5'd1, 5'd9, 1, 5'd9, 0, 0, 0, 1, V_LU);
    step("lu_opimm_rs2", 0, OPIMM, 5'd1, 5'd9, 1, 5'd9, 0, 0, 0, 1, V_NONE);
    step("lu_lui",   0, LUI, 5'd5, 5'd5, 1, 5'd5, 0, 0, 0, 1, V_NONE);
    step("lu_dest0", 0, OP,  5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 1, V_NONE);
    step("lu_nomr",  0, OP,  5'd5, 5'd7, 0, 5'd5, 0, 0, 0, 1, V_NONE);
    step("lu_redir", 0, OP,  5'd5, 5'd7, 1, 5'd5, 1, 0, 0, 1, V_RED);
    step("mem_1cyc", 0, OP,  5'd1, 5'd2, 0, 5'd0, 0, 1, 1, 1, V_NONE);

    // Three not-ready cycles, then ready: four stall cycles with a redirect held throughout.
    step("mw_req",   0, OP, 5'd5, 5'd7, 1, 5'd5, 1, 1, 0, 1, V_MEM);
    step("mw_w1",    0, OP, 5'd5, 5'd7, 1, 5'd5, 1, 1, 0, 1, V_MEM);
    step("mw_w2",    0, OP, 5'd5, 5'd7, 1, 5'd5, 1, 1, 0, 1, V_MEM);
    step("mw_rel",   0, OP, 5'd5, 5'd7, 1, 5'd5, 1, 1, 1, 1, V_MEM);
    step("mw_redir", 0, OP, 5'd5, 5'd7, 1, 5'd5, 1, 0, 0, 1, V_RED);
    step("mw_idle",  0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, V_NONE);

    // Held not-ready long enough to time out; flag is sticky past release.
    for (int i = 0; i < 7; i++) step("to_wait", 0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, 1, V_MEM);
    step("to_rel",   0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1, 1, V_MEM);
    step("to_stick", 0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, V_NONE);
    step("to_stick2", 0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, V_NONE);
    step("to_rst",   1, OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, V_NONE);
    step("to_clr",   0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, V_NONE);

    // Reset in MEM_WAIT, then a dropped request.
    step("rw_req",   0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, 1, V_MEM);
    step("rw_w",     0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, 1, V_MEM);
    step("rw_rst",   1, OP, 5'd1, 5'd2, 0, 5'd0, 1, 1, 0, 1, V_NONE);
    step("rw_run",   0, OP, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0, 1, V_RED);
    step("drop_req", 0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, 1, V_MEM);
    step("drop_w",   0, OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 1, V_MEM);
    step("drop_run", 0, OP, 5'd5, 5'd2, 1, 5'd5, 0, 0, 0, 1, V_LU);

    for (int i = 0; i < 800; i++) begin
      step("rand", ($urandom_range(0, 59) == 0), opc_tab[$urandom_range(0, 9)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
